// File: rtl/rf_iw_dpdb_ctrl.sv
// Bank-swap controller for the dual-port double-buffer activation/weight RF.
// Fills one bank from the global buffer while the MAC drains the other with per-tile reuse.
module rf_iw_dpdb_ctrl #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 2,
    parameter int DEPTH         = 4,
    parameter int REUSE         = 2,
    parameter int TILE_BITWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TILE_BITWIDTH-1:0] cfg_tiles,
    input  logic                     gb_valid,
    input  logic [DATA_BITWIDTH-1:0] gb_data,
    output logic                     gb_ready,
    input  logic                     mac_ready,
    output logic                     write_sel,
    output logic                     write_en,
    output logic [ADDR_BITWIDTH-1:0] w_addr,
    output logic [DATA_BITWIDTH-1:0] w_data,
    output logic [ADDR_BITWIDTH-1:0] r_addr,
    output logic                     rd_valid,
    output logic                     rd_sel,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     done
);

    localparam int PASS_W = (REUSE > 1) ? $clog2(REUSE) : 1;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);
    localparam logic [PASS_W-1:0]        LAST_PASS = PASS_W'(REUSE - 1);

    typedef enum logic [1:0] {F_IDLE, F_FILL, F_FULL} fill_state_e;
    typedef enum logic       {R_IDLE, R_DRAIN}        read_state_e;

    fill_state_e              fill_q, fill_d;
    read_state_e              read_q, read_d;
    logic                     write_sel_q, write_sel_d;
    logic [ADDR_BITWIDTH-1:0] fill_idx_q, fill_idx_d;
    logic [ADDR_BITWIDTH-1:0] r_addr_q, r_addr_d;
    logic [PASS_W-1:0]        pass_q, pass_d;
    logic [TILE_BITWIDTH-1:0] cfg_q, cfg_d;
    logic [TILE_BITWIDTH-1:0] fetched_q, fetched_d;
    logic [TILE_BITWIDTH-1:0] drained_q, drained_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     rd_sel_q, rd_sel_d;
    logic                     rd_last_q, rd_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic accept_start, hs, issue, last_issue, swap;

    always_comb begin
        fill_d      = fill_q;
        read_d      = read_q;
        write_sel_d = write_sel_q;
        fill_idx_d  = fill_idx_q;
        r_addr_d    = r_addr_q;
        pass_d      = pass_q;
        cfg_d       = cfg_q;
        fetched_d   = fetched_q;
        drained_d   = drained_q;
        busy_d      = busy_q;

        accept_start = start & ~busy_q;
        hs           = gb_valid & (fill_q == F_FILL);
        issue        = (read_q == R_DRAIN) & mac_ready;
        last_issue   = issue & (r_addr_q == LAST_ADDR) & (pass_q == LAST_PASS);
        // The next tile may swap in on the very cycle the old one issues its last address.
        swap         = (fill_q == F_FULL) & ((read_q == R_IDLE) | last_issue);

        if (swap) begin
            write_sel_d = ~write_sel_q;
        end

        case (fill_q)
            F_FILL: begin
                if (hs) begin
                    if (fill_idx_q == LAST_ADDR) begin
                        fill_idx_d = '0;
                        fill_d     = F_FULL;
                        fetched_d  = fetched_q + TILE_BITWIDTH'(1);
                    end else begin
                        fill_idx_d = fill_idx_q + ADDR_BITWIDTH'(1);
                    end
                end
            end
            F_FULL: begin
                if (swap) begin
                    fill_d = (fetched_q < cfg_q) ? F_FILL : F_IDLE;
                end
            end
            default: fill_d = F_IDLE;
        endcase

        if (accept_start) begin
            cfg_d = cfg_tiles;
            if (cfg_tiles != '0) begin
                fill_d     = F_FILL;
                fill_idx_d = '0;
                fetched_d  = '0;
                drained_d  = '0;
                busy_d     = 1'b1;
            end
        end

        case (read_q)
            R_IDLE: begin
                if (swap) begin
                    read_d   = R_DRAIN;
                    r_addr_d = '0;
                    pass_d   = '0;
                end
            end
            R_DRAIN: begin
                if (issue) begin
                    if (r_addr_q == LAST_ADDR) begin
                        r_addr_d = '0;
                        if (pass_q == LAST_PASS) begin
                            pass_d    = '0;
                            drained_d = drained_q + TILE_BITWIDTH'(1);
                            read_d    = swap ? R_DRAIN : R_IDLE;
                        end else begin
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        r_addr_d = r_addr_q + ADDR_BITWIDTH'(1);
                    end
                end
            end
            default: read_d = R_IDLE;
        endcase

        // rd_sel captures the read bank at issue, so a later bank toggle cannot corrupt it.
        rd_valid_d = issue;
        rd_sel_d   = ~write_sel_q;
        rd_last_d  = last_issue;

        done_d = (accept_start & (cfg_tiles == '0))
               | (busy_q & rd_valid_q & rd_last_q & (drained_q == cfg_q));
        if (done_d) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_q      <= F_IDLE;
            read_q      <= R_IDLE;
            write_sel_q <= 1'b1;
            fill_idx_q  <= '0;
            r_addr_q    <= '0;
            pass_q      <= '0;
            cfg_q       <= '0;
            fetched_q   <= '0;
            drained_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            read_q      <= read_d;
            write_sel_q <= write_sel_d;
            fill_idx_q  <= fill_idx_d;
            r_addr_q    <= r_addr_d;
            pass_q      <= pass_d;
            cfg_q       <= cfg_d;
            fetched_q   <= fetched_d;
            drained_q   <= drained_d;
            rd_valid_q  <= rd_valid_d;
            rd_sel_q    <= rd_sel_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign gb_ready  = (fill_q == F_FILL);
    assign write_en  = gb_valid & gb_ready;
    assign w_addr    = fill_idx_q;
    assign w_data    = gb_data;
    assign write_sel = write_sel_q;
    assign r_addr    = r_addr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_sel    = rd_sel_q;
    assign rd_last   = rd_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rf_iw_dpdb_ctrl.sv
// Bench for rf_iw_dpdb_ctrl: directed jobs plus random traffic against a
// count-based reference model of fill, bank swap and reuse draining.
module tb_rf_iw_dpdb_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int REUSE = 2;
    localparam int TW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [TW-1:0] cfg_tiles;
    logic          gb_valid;
    logic [DW-1:0] gb_data;
    logic          gb_ready;
    logic          mac_ready;
    logic          write_sel;
    logic          write_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW-1:0] r_addr;
    logic          rd_valid;
    logic          rd_sel;
    logic          rd_last;
    logic          busy;
    logic          done;

    rf_iw_dpdb_ctrl #(
        .DATA_BITWIDTH(DW),
        .ADDR_BITWIDTH(AW),
        .DEPTH(DEPTH),
        .REUSE(REUSE),
        .TILE_BITWIDTH(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_tiles(cfg_tiles),
        .gb_valid(gb_valid), .gb_data(gb_data), .gb_ready(gb_ready),
        .mac_ready(mac_ready), .write_sel(write_sel), .write_en(write_en),
        .w_addr(w_addr), .w_data(w_data), .r_addr(r_addr), .rd_valid(rd_valid),
        .rd_sel(rd_sel), .rd_last(rd_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: words accepted into the filling tile, issues left in the draining tile.
    bit m_busy, m_done, m_wsel, m_fill, m_rv, m_rsel, m_rlast;
    int m_cfg, m_acc, m_fetched, m_iss, m_drained;
    bit saw_done;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_wsel = 1; m_fill = 0;
        m_rv = 0; m_rsel = 0; m_rlast = 0;
        m_cfg = 0; m_acc = 0; m_fetched = 0; m_iss = 0; m_drained = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        bit e_gbr, e_we, issue, fin, full, swap, n_done;
        int e_waddr, e_raddr;
        @(negedge clk);
        e_gbr   = m_fill && (m_acc < DEPTH);
        e_we    = gb_valid && e_gbr;
        e_waddr = m_acc % DEPTH;
        e_raddr = (m_iss > 0) ? (DEPTH * REUSE - m_iss) % DEPTH : 0;
        chk("gb_ready",  32'(gb_ready),  32'(e_gbr));
        chk("write_en",  32'(write_en),  32'(e_we));
        if (e_we) begin
            chk("w_addr", 32'(w_addr), 32'(e_waddr));
            chk("w_data", 32'(w_data), 32'(gb_data));
        end
        chk("write_sel", 32'(write_sel), 32'(m_wsel));
        chk("r_addr",    32'(r_addr),    32'(e_raddr));
        chk("rd_valid",  32'(rd_valid),  32'(m_rv));
        if (m_rv) chk("rd_sel", 32'(rd_sel), 32'(m_rsel));
        chk("rd_last",   32'(rd_last),   32'(m_rlast));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("done",      32'(done),      32'(m_done));
        if (m_done) saw_done = 1;

        if (!reset) begin
            model_reset();
        end else begin
            issue  = (m_iss > 0) && mac_ready;
            fin    = issue && (m_iss == 1);
            full   = m_fill && (m_acc == DEPTH);
            swap   = full && ((m_iss == 0) || fin);
            n_done = (m_rv && m_rlast && (m_drained == m_cfg))
                   || (start && !m_busy && (cfg_tiles == 0));
            m_rv    = issue;
            m_rsel  = !m_wsel;
            m_rlast = fin;
            if (fin) m_drained++;
            if (issue) m_iss--;
            if (e_we) begin
                m_acc++;
                if (m_acc == DEPTH) m_fetched++;
            end
            if (swap) begin
                m_wsel = !m_wsel;
                m_iss  = DEPTH * REUSE;
                m_acc  = 0;
                m_fill = (m_fetched < m_cfg);
            end
            if (start && !m_busy && (cfg_tiles != 0)) begin
                m_busy = 1; m_cfg = int'(cfg_tiles); m_fill = 1;
                m_acc = 0; m_fetched = 0; m_drained = 0;
            end
            m_done = n_done;
            if (n_done) m_busy = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // vmode/mmode: 0 = always high, 1 = sparse (every 3rd) / toggling, 2 = random.
    task automatic run_job(input int cfg, input int vmode, input int mmode,
                           input int abort_at, input int mid_start);
        bit aborted;
        aborted  = 0;
        saw_done = 0;
        start = 1; cfg_tiles = TW'(cfg); gb_valid = 0; mac_ready = 0;
        cycle();
        start = 0;
        for (int n = 1; n <= 400; n++) begin
            cfg_tiles = TW'($urandom_range(0, 9));
            gb_data   = DW'($urandom);
            case (vmode)
                0:       gb_valid = 1;
                1:       gb_valid = (n % 3 == 0);
                default: gb_valid = 1'($urandom_range(0, 1));
            endcase
            case (mmode)
                0:       mac_ready = 1;
                1:       mac_ready = (n % 2 == 1);
                default: mac_ready = 1'($urandom_range(0, 1));
            endcase
            if (n == mid_start) begin
                start = 1; cfg_tiles = 7;
            end
            if (n == abort_at) begin
                reset = 0; aborted = 1;
            end
            cycle();
            start = 0;
            reset = 1;
            if (aborted || saw_done) break;
        end
        chk("job_end", 32'(saw_done | aborted), 32'd1);
        gb_valid = 0; mac_ready = 0;
        cycle();
        cycle();
    endtask

    initial begin
        reset = 0; start = 0; cfg_tiles = '0; gb_valid = 0; gb_data = '0; mac_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        reset = 1;
        cycle();
        cycle();

        run_job(1, 0, 0, 0, 0);
        run_job(3, 0, 0, 0, 0);
        run_job(2, 0, 1, 0, 0);
        run_job(2, 1, 0, 0, 0);
        run_job(0, 0, 0, 0, 0);
        run_job(3, 2, 2, 0, 10);
        run_job(3, 0, 0, 17, 0);
        run_job(1, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 4), 2, 2, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
